// File: rtl/slave_sci_line_pacer_if.sv
// Byte-stream handshake between the master-side feed and the slave SCI pacer.
interface slave_sci_line_pacer_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [7:0]       in_data;
    logic             in_write;
    logic             rts_n;
    logic             overflow_clr;
    logic [7:0]       out_data;
    logic             out_write;
    logic             line_tx;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;

    modport master (
        output in_data, in_write, rts_n, overflow_clr,
        input  out_data, out_write, line_tx, busy, fifo_level, overflow
    );

    modport slave (
        input  in_data, in_write, rts_n, overflow_clr,
        output out_data, out_write, line_tx, busy, fifo_level, overflow
    );
endinterface

// File: rtl/slave_sci_line_pacer.sv
// Buffers master-side bytes and releases them to the slave SCI one per
// 10-bit UART frame time, with a reconstructed TX line for debug.
module slave_sci_line_pacer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 3125
) (
    input  logic                  clk30,
    input  logic                  reset,
    slave_sci_line_pacer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_idx;

    logic pop_c;
    logic push_c;
    logic drop_c;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop_c  = (state == IDLE) && (level != '0) && !bus.rts_n;
    assign push_c = bus.in_write && ((level != LVL_W'(DEPTH)) || pop_c);
    assign drop_c = bus.in_write && !push_c;

    assign bus.fifo_level = level;

    always_ff @(posedge clk30) begin
        if (push_c) mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk30) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop_c)                bus.overflow <= 1'b1;
            else if (bus.overflow_clr) bus.overflow <= 1'b0;
        end
    end

    // Frame sequencer; line_tx is loaded with the level of the bit being entered
    always_ff @(posedge clk30) begin
        if (reset) begin
            state         <= IDLE;
            shift_reg     <= '0;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            bus.out_data  <= '0;
            bus.out_write <= 1'b0;
            bus.line_tx   <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            bus.out_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        shift_reg   <= mem[rd_ptr];
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        bus.line_tx <= 1'b0;
                        bus.busy    <= 1'b1;
                        state       <= FRAME;
                    end
                end
                FRAME: begin
                    if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bus.out_write <= 1'b1;
                            bus.out_data  <= shift_reg;
                            bus.line_tx   <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= DELIVER;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            if (bit_idx == 4'd8) bus.line_tx <= 1'b1;
                            else                 bus.line_tx <= shift_reg[bit_idx[2:0]];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DELIVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_sci_line_pacer.sv
// Bench for slave_sci_line_pacer: directed spec scenarios plus random traffic,
// checked every cycle against a frame-timing reference model.
module tb_slave_sci_line_pacer;
    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FR    = 10 * C;

    logic clk30 = 1'b0;
    logic reset = 1'b1;
    always #5 clk30 = ~clk30;

    slave_sci_line_pacer_if #(.DEPTH(DEPTH)) bus ();

    slave_sci_line_pacer #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
        .clk30 (clk30),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queue of bytes and the start cycle of the current frame
    logic [7:0] q[$];
    int         cyc       = 0;
    int         cur_start = -1;
    int         next_free = 0;
    logic [7:0] cur_byte  = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic       m_ovf     = 1'b0;
    logic [14:0] exp_v    = '0;
    logic [14:0] obs;

    assign obs = {bus.out_write, bus.out_data, bus.line_tx, bus.busy, bus.fifo_level, bus.overflow};

    task automatic model_step();
        logic popped, ow, ln, bz;
        int rel, b;
        if (reset) begin
            q.delete();
            cur_start = -1;
            next_free = cyc + 1;
            m_ovf     = 1'b0;
            last_data = 8'h00;
        end else begin
            popped = 1'b0;
            if (cyc >= next_free && q.size() > 0 && !bus.rts_n) begin
                cur_start = cyc;
                cur_byte  = q.pop_front();
                next_free = cyc + FR + 2;
                popped    = 1'b1;
            end
            if (bus.overflow_clr) m_ovf = 1'b0;
            if (bus.in_write) begin
                if (q.size() < DEPTH) q.push_back(bus.in_data);
                else                  m_ovf = 1'b1;
            end
        end
        cyc++;
        ow = 1'b0; ln = 1'b1; bz = 1'b0;
        if (cur_start >= 0) begin
            rel = cyc - cur_start;
            if (rel >= 1 && rel <= FR) begin
                bz = 1'b1;
                b  = (rel - 1) / C;
                if (b == 0)      ln = 1'b0;
                else if (b == 9) ln = 1'b1;
                else             ln = cur_byte[b-1];
            end else if (rel == FR + 1) begin
                ow        = 1'b1;
                last_data = cur_byte;
            end
        end
        exp_v = {ow, last_data, ln, bz, 3'(q.size()), m_ovf};
    endtask

    task automatic tick();
        @(posedge clk30);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_write     = 1'b0;
        bus.in_data      = 8'h00;
        bus.rts_n        = 1'b0;
        bus.overflow_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== {1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_initial obs=%h required=%h", obs, {1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0});
        end
        for (int t = 0; t < 12; t++) begin
            bus.in_write = (t < 3);
            bus.in_data  = 8'h40 + 8'(t);
            tick();
        end
        idle_inputs();
        do_reset();
        n_tests++;
        if (obs !== {1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_busy obs=%h required=%h", obs, {1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0});
        end
    endtask

    task automatic test_single();
        int n_strobe = 0, st_t = -1;
        logic [7:0] st_d = 8'h00;
        logic [9:0] line_seq = '0;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL single_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (bus.out_write) begin n_strobe++; st_t = t; st_d = bus.out_data; end
            if (t >= 2 && t < 42 && ((t - 2) % C) == 0) line_seq[(t-2)/C] = bus.line_tx;
            bus.in_write = (t == 0);
            bus.in_data  = 8'hA5;
            tick();
        end
        idle_inputs();
        n_tests++;
        if (n_strobe != 1 || st_t != 42 || st_d !== 8'hA5) begin
            n_fail++; $display("FAIL single_strobe count=%0d cycle=%0d data=%h required 1/42/a5", n_strobe, st_t, st_d);
        end
        n_tests++;
        if (line_seq !== 10'b1101001010) begin
            n_fail++; $display("FAIL single_line obs=%b required=%b", line_seq, 10'b1101001010);
        end
    endtask

    task automatic test_burst();
        int n_strobe = 0, peak = 0;
        int st_t[4];
        logic [7:0] st_d[4];
        do_reset();
        for (int t = 0; t < 170; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL burst_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (bus.out_write && n_strobe < 4) begin st_t[n_strobe] = t; st_d[n_strobe] = bus.out_data; n_strobe++; end
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
            bus.in_write = (t < 3);
            bus.in_data  = 8'(t + 1);
            tick();
        end
        idle_inputs();
        n_tests++;
        if (n_strobe != 3) begin
            n_fail++; $display("FAIL burst_count obs=%0d required=3", n_strobe);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (st_t[i] != 42 * (i + 1) || st_d[i] !== 8'(i + 1)) begin
                    n_fail++; $display("FAIL burst_strobe%0d cycle=%0d data=%h required %0d/%h", i, st_t[i], st_d[i], 42 * (i + 1), 8'(i + 1));
                end
            end
        end
        n_tests++;
        if (peak != 2) begin
            n_fail++; $display("FAIL burst_peak obs=%0d required=2", peak);
        end
    endtask

    task automatic test_overflow();
        int n_strobe = 0;
        logic [7:0] st_d[6];
        do_reset();
        for (int t = 0; t < 5 * 42 + 10; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL ovf_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (bus.out_write && n_strobe < 6) begin st_d[n_strobe] = bus.out_data; n_strobe++; end
            bus.in_write = (t < 6);
            bus.in_data  = 8'h10 + 8'(t);
            tick();
        end
        idle_inputs();
        n_tests++;
        if (n_strobe != 5 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drop count=%0d overflow=%b required 5/1", n_strobe, bus.overflow);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (st_d[i] !== 8'h10 + 8'(i)) begin
                    n_fail++; $display("FAIL ovf_data%0d obs=%h required=%h", i, st_d[i], 8'h10 + 8'(i));
                end
            end
        end
        for (int t = 0; t < 4; t++) begin
            bus.overflow_clr = (t == 0);
            tick();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL ovf_clr_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
        end
        n_tests++;
        if (bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear obs=%b required=0", bus.overflow);
        end
    endtask

    task automatic test_flow();
        int n_strobe = 0, st_t = -1;
        logic [7:0] st_d = 8'h00;
        do_reset();
        for (int t = 0; t < 160; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL flow_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (t == 99) begin
                n_tests++;
                if (bus.fifo_level !== 3'd1 || bus.busy !== 1'b0 || n_strobe != 0) begin
                    n_fail++; $display("FAIL flow_blocked level=%0d busy=%b strobes=%0d required 1/0/0", bus.fifo_level, bus.busy, n_strobe);
                end
            end
            if (bus.out_write) begin n_strobe++; st_t = t; st_d = bus.out_data; end
            bus.in_write = (t == 0);
            bus.in_data  = 8'h55;
            bus.rts_n    = (t < 100) || (t >= 120);
            tick();
        end
        idle_inputs();
        n_tests++;
        if (n_strobe != 1 || st_t != 141 || st_d !== 8'h55) begin
            n_fail++; $display("FAIL flow_strobe count=%0d cycle=%0d data=%h required 1/141/55", n_strobe, st_t, st_d);
        end
    endtask

    task automatic test_reset_mid();
        int n_strobe = 0;
        do_reset();
        for (int t = 0; t < 100; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL rstmid_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (t == 21) begin
                n_tests++;
                if (bus.line_tx !== 1'b1 || bus.busy !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_line line_tx=%b busy=%b required 1/0", bus.line_tx, bus.busy);
                end
            end
            if (bus.out_write) n_strobe++;
            bus.in_write = (t == 0);
            bus.in_data  = 8'hFF;
            reset        = (t == 20);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        n_tests++;
        if (n_strobe != 0 || bus.line_tx !== 1'b1 || bus.fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_final strobes=%0d line_tx=%b level=%0d required 0/1/0", n_strobe, bus.line_tx, bus.fifo_level);
        end
    endtask

    task automatic test_full_pushpop();
        int n_strobe = 0;
        logic [7:0] st_d[7];
        do_reset();
        for (int t = 0; t < 6 * 42 + 10; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL full_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (t == 43) begin
                n_tests++;
                if (bus.fifo_level !== 3'd4) begin
                    n_fail++; $display("FAIL full_level obs=%0d required=4", bus.fifo_level);
                end
            end
            if (bus.out_write && n_strobe < 7) begin st_d[n_strobe] = bus.out_data; n_strobe++; end
            bus.in_write = (t < 5) || (t == 43);
            bus.in_data  = (t == 43) ? 8'h35 : 8'h30 + 8'(t);
            tick();
        end
        idle_inputs();
        n_tests++;
        if (n_strobe != 6 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_count strobes=%0d overflow=%b required 6/0", n_strobe, bus.overflow);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (st_d[i] !== 8'h30 + 8'(i)) begin
                    n_fail++; $display("FAIL full_data%0d obs=%h required=%h", i, st_d[i], 8'h30 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 1100; t++) begin
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++; if (n_fail < 20) $display("FAIL random_cycle t=%0d obs=%h exp=%h", t, obs, exp_v);
            end
            if (t < 800) begin
                bus.in_write     = ($urandom_range(0, 5) == 0);
                bus.in_data      = 8'($urandom);
                bus.overflow_clr = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 31) == 0) bus.rts_n = ~bus.rts_n;
            end else begin
                idle_inputs();
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_flow();
        test_reset_mid();
        test_full_pushpop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
